// File: rtl/lianliankan_pkg.sv
// Shared definitions for the lianliankan front end: per-button channel state
// encoding and the default timing constants (100 MHz board clock).
package lianliankan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PRESS_DB    = 3'd1,
      ST_HELD_DELAY  = 3'd2,
      ST_HELD_REPEAT = 3'd3,
      ST_RELEASE_DB  = 3'd4
   } chan_state_e;

   // 10 ms debounce, 400 ms to first repeat, 150 ms between repeats.
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 40_000_000;
   localparam int DEF_REPEAT_PERIOD   = 15_000_000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM with a
// saturating counter, and a registered single-cycle pulse output.
module btn_channel
   import lianliankan_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_P  = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW     = $clog2(MAX_P);

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

   logic [1:0]    sync_q, sync_d;
   chan_state_e   state_q, state_d;
   chan_state_e   ret_q, ret_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          fire_q, fire_d;
   logic          pulse_q, pulse_d;
   logic          s;

   assign s     = sync_q[1];
   assign pulse = pulse_q;

   // Synchronizer shift and pulse pipeline: a fire decision shows up on the
   // output one cycle after the FSM takes it.
   always_comb begin
      sync_d  = {sync_q[0], btn};
      pulse_d = fire_q;
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   end

   // Channel FSM: debounce press/release, time the initial and repeat pulses.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      fire_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s) begin
               state_d = ST_PRESS_DB;
               cnt_d   = CW'(1);
            end
         end
         ST_PRESS_DB: begin
            if (!s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_HELD_DELAY;
               cnt_d   = '0;
               fire_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HELD_DELAY: begin
            // Release takes priority over a repeat falling on the same cycle.
            if (!s) begin
               state_d = ST_RELEASE_DB;
               ret_d   = ST_HELD_DELAY;
               cnt_d   = CW'(1);
            end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
               state_d = ST_HELD_REPEAT;
               cnt_d   = '0;
               fire_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;   // select channel parks here, saturated
            end
         end
         ST_HELD_REPEAT: begin
            if (!s) begin
               state_d = ST_RELEASE_DB;
               ret_d   = ST_HELD_REPEAT;
               cnt_d   = CW'(1);
            end else if (cnt_q == PER_LAST) begin
               cnt_d  = '0;
               fire_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RELEASE_DB: begin
            // A glitch back to 1 resumes the held phase with a fresh timer.
            if (s) begin
               state_d = ret_q;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, synchronizer and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         cnt_q   <= '0;
         fire_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
         pulse_q <= pulse_d;
      end
   end

endmodule

// File: rtl/button_pulser.sv
// Five independent button channels feeding the grid cursor (directions,
// auto-repeating) and the tile-pick logic (select, single shot).
module button_pulser
   import lianliankan_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_sel,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic sel
);

   btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_up (.clk(clk), .rst_n(rst_n), .btn(btn_up), .pulse(up));

   btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_down (.clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(down));

   btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_left (.clk(clk), .rst_n(rst_n), .btn(btn_left), .pulse(left));

   btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .pulse(right));

   // Select never auto-repeats: one pick per press.
   btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
   ) u_sel (.clk(clk), .rst_n(rst_n), .btn(btn_sel), .pulse(sel));

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: directed scenarios followed by random button
// activity, checked cycle by cycle against an event-time reference model.
module tb_button_pulser;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] raw = '0;   // bit order: up, down, left, right, sel
   logic       up, down, left, right, sel;
   logic [4:0] dut_out;

   assign dut_out = {sel, right, left, down, up};

   button_pulser #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(raw[0]), .btn_down(raw[1]), .btn_left(raw[2]),
      .btn_right(raw[3]), .btn_sel(raw[4]),
      .up(up), .down(down), .left(left), .right(right), .sel(sel)
   );

   int checks = 0;
   int errors = 0;
   int sel_cnt = 0;

   logic [4:0] exp_q[$];

   // ---------------- reference model ----------------
   // Per button: the synchronized level seen each edge, how many edges it has
   // kept that level, whether the press is accepted, and the absolute edge at
   // which the next repeat is due.
   logic [1:0] m_sync[5];
   bit         m_last[5];
   int         m_run[5];
   bit         m_pressed[5];
   bit         m_repeated[5];
   int         m_next[5];
   logic [4:0] m_fire_prev;
   int         edge_n = 0;

   task automatic model_step();
      logic [4:0] fire_now;
      bit         s;
      fire_now = '0;
      edge_n++;
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin
            m_sync[i] = '0; m_last[i] = 1'b0; m_run[i] = 0;
            m_pressed[i] = 1'b0; m_repeated[i] = 1'b0; m_next[i] = 0;
         end
         m_fire_prev = '0;
         exp_q.push_back(5'b0);
      end else begin
         exp_q.push_back(m_fire_prev);
         for (int i = 0; i < 5; i++) begin
            s = m_sync[i][1];
            m_sync[i] = {m_sync[i][0], raw[i]};
            if (s == m_last[i]) m_run[i]++;
            else m_run[i] = 1;
            m_last[i] = s;
            if (!m_pressed[i]) begin
               if (s && m_run[i] == DB) begin
                  m_pressed[i]  = 1'b1;
                  m_repeated[i] = 1'b0;
                  m_next[i]     = edge_n + RD;
                  fire_now[i]   = 1'b1;
               end
            end else if (!s) begin
               if (m_run[i] == DB) m_pressed[i] = 1'b0;
            end else if (m_run[i] == 1) begin
               m_next[i] = edge_n + (m_repeated[i] ? RP : RD);
            end else if (i != 4 && edge_n == m_next[i]) begin
               fire_now[i]   = 1'b1;
               m_repeated[i] = 1'b1;
               m_next[i]     = edge_n + RP;
            end
         end
         m_fire_prev = fire_now;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- scoreboard monitor ----------------
   initial forever begin
      logic [4:0] exp_v;
      logic [4:0] req;
      @(negedge clk);
      if (sel) sel_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_underflow t=%0t: got %b with no expected entry", $time, dut_out);
      end else begin
         exp_v = exp_q.pop_front();
         req   = rst_n ? exp_v : 5'b0;
         if (dut_out !== req) begin
            errors++;
            $display("FAIL pulses t=%0t: got {sel,r,l,d,u}=%b required %b", $time, dut_out, req);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raw was just changed; count edges after the sampling edge until up shows.
   task automatic measure_up_latency();
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      @(posedge clk);
      while (!seen && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (up) seen = 1'b1;
      end
      checks++;
      if (!seen || n != DB + 2) begin
         errors++;
         $display("FAIL up_latency: got %0d edges (seen=%0b), required %0d", n, seen, DB + 2);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      raw   = '0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // clean press
      raw[0] = 1'b1;
      measure_up_latency();
      step(4);
      raw[0] = 1'b0;
      step(DB + 4);

      // auto-repeat on right
      raw[3] = 1'b1;
      step(30);
      raw[3] = 1'b0;
      step(DB + 4);

      // long select hold: exactly one pulse
      sel_cnt = 0;
      raw[4] = 1'b1;
      step(40);
      raw[4] = 1'b0;
      step(DB + 4);
      checks++;
      if (sel_cnt != 1) begin
         errors++;
         $display("FAIL sel_single_shot: got %0d pulses, required 1", sel_cnt);
      end

      // bounce on left
      raw[2] = 1'b1; step(1);
      raw[2] = 1'b0; step(1);
      raw[2] = 1'b1; step(1);
      raw[2] = 1'b0; step(DB + 4);

      // release glitch on down while repeating
      raw[1] = 1'b1;
      step(DB + 2 + RD + RP + 2);
      raw[1] = 1'b0;
      step(2);
      raw[1] = 1'b1;
      step(10);
      raw[1] = 1'b0;
      step(DB + 4);

      // simultaneous up + left
      raw[0] = 1'b1;
      raw[2] = 1'b1;
      step(8);
      raw = '0;
      step(DB + 4);

      // reset mid-hold
      raw[0] = 1'b1;
      step(20);
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(12);
      raw[0] = 1'b0;
      step(DB + 4);

      // random segments, occasional reset
      for (int seg = 0; seg < 70; seg++) begin
         raw = 5'($urandom);
         step($urandom_range(1, 2 * DB + RD));
         if ($urandom_range(0, 15) == 0) begin
            rst_n = 1'b0;
            step($urandom_range(1, 3));
            rst_n = 1'b1;
         end
      end

      raw = '0;
      step(DB + 6);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_pulser.md
# button_pulser

Front-end conditioner that sits directly upstream of the 6×6 grid cursor. It turns five raw, bouncing board push-buttons into clean single-cycle pulses: up, down, left, right and select. The four direction pulses drive the cursor's up/down/left/right inputs. The select pulse goes to the tile-pick logic. Direction buttons auto-repeat while held, so holding a direction sweeps the cursor across the grid.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized cycles required to accept a press or a release (10 ms at 100 MHz); ≥2.
- `REPEAT_DELAY`, default 40_000_000: cycles from the initial pulse to the first auto-repeat pulse; ≥2.
- `REPEAT_PERIOD`, default 15_000_000: cycles between successive auto-repeat pulses; ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous and active-low; one clock.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`  in  1 each  raw buttons, asynchronous, active-high.
- `up`, `down`, `left`, `right`  out  1 each  single-cycle direction pulses, registered.
- `sel`  out  1  single-cycle select pulse, registered, never repeats.

## Operation
- Each button passes through a 2-flop synchronizer and then an independent channel FSM. The synchronizer output is called `s`.
- Channel states:
  - IDLE
  - PRESS_DB
  - HELD_DELAY
  - HELD_REPEAT
  - RELEASE_DB
- IDLE:
  - s=1 → PRESS_DB, with cnt=1.
- PRESS_DB:
  - s=0 → IDLE, cnt=0, no pulse.
  - s=1 and cnt==DEBOUNCE_CYCLES-1 → HELD_DELAY; pulse asserted next cycle; cnt=0.
  - Otherwise cnt++.
- HELD_DELAY (direction channels):
  - cnt counts up.
  - At cnt==REPEAT_DELAY-1: pulse, → HELD_REPEAT, cnt=0.
- HELD_REPEAT:
  - At cnt==REPEAT_PERIOD-1: pulse, cnt=0.
- Select channel: repeat is disabled, so it stays in HELD_DELAY with cnt saturated and emits no further pulses.
- Any HELD state with s=0 → RELEASE_DB, cnt=1. The state being left is remembered as `ret`.
- RELEASE_DB:
  - s=1 → back to `ret` with cnt=0, which restarts the repeat phase. No pulse.
  - s=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, cnt=0.
  - No pulses are emitted while in RELEASE_DB.
- Counter width is $clog2 of the largest parameter. Counters saturate and never wrap.
- Channels are fully independent. Simultaneous presses may produce simultaneous pulses; the cursor already resolves those.
- Reset:
  - All FSMs go to IDLE, counters and synchronizer flops to 0, all outputs to 0.
  - A reset mid-hold drops the press. After reset is released, a still-held button is re-debounced and produces a fresh initial pulse.

## Timing
- Each output pulse is exactly 1 cycle wide.
- Press latency: raw 0→1 sampled at edge k (held stable) → pulse high in the cycle after edge k+DEBOUNCE_CYCLES+2. That is DEBOUNCE_CYCLES+2 cycles after the raw change.
- First repeat pulse: REPEAT_DELAY cycles after the initial pulse.
- Later repeat pulses: every REPEAT_PERIOD cycles after that.
- A press bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- A release glitch shorter than DEBOUNCE_CYCLES produces no new initial pulse. It restarts the repeat timer from 0, and the next pulse comes REPEAT_DELAY or REPEAT_PERIOD cycles after s returns high, depending on `ret`.
- Minimum press-to-press interval for a second initial pulse: 2·DEBOUNCE_CYCLES from the first pulse.

## Structure
- Shared package `lianliankan_pkg` holds:
  - the channel state encoding (IDLE, PRESS_DB, HELD_DELAY, HELD_REPEAT, RELEASE_DB, 3 bits);
  - the default timing constants.
- Sub-module `btn_channel` contains the synchronizer, FSM, counter and pulse register.
  - It has a `REPEAT_EN` parameter: 1 for the four direction channels, 0 for select.
  - `button_pulser` instantiates it five times.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_up held high from edge 0 → `up` is 1 for one cycle, 6 cycles after the raw change; `down`/`left`/`right`/`sel` stay 0.
- Auto-repeat: btn_right held for 30 cycles → one initial pulse, then pulses 10, 13, 16, … cycles after it; a long btn_sel hold → exactly one `sel` pulse.
- Bounce: btn_left toggles 1,0,1,0 at 1-cycle intervals and then settles at 0 → no `left` pulse; the FSM returns to IDLE.
- Release glitch: btn_down held, then a 2-cycle low dropout while in HELD_REPEAT → no new initial pulse; next repeat pulse 3 cycles after s returns high.
- Simultaneous: btn_up and btn_left rise on the same edge → `up` and `left` pulse in the same cycle.
- Reset mid-hold: btn_up held, rst_n asserted low for 3 cycles mid-repeat → all outputs 0 immediately; after release, fresh initial pulse 6 cycles later.
